// File: rtl/step_ctrl_pkg.sv
// Shared types and default widths for the run/step controller.
package step_ctrl_pkg;

  localparam int XLEN_DEF = 32;
  localparam int CNTW_DEF = 8;

  typedef enum logic [1:0] {
    ST_PAUSE  = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_BPHALT = 2'd3
  } state_t;

endpackage

// File: rtl/step_ctrl.sv
// Run/step controller gating the core clock-enable from debounced button pulses.
//
// state  | meaning
// -------+-----------------------------------------------------------
// PAUSE  | core held, waiting for run or step request
// RUN    | core free-running until run toggle or breakpoint
// STEP   | core enabled for a burst of remain_q retires
// BPHALT | core held after a retire whose next-PC hit the breakpoint
module step_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int CNTW = CNTW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run_pulse_i,
  input  logic            step_pulse_i,
  input  logic [CNTW-1:0] step_cnt_i,
  input  logic            bp_en_i,
  input  logic [XLEN-1:0] bp_addr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            retire_i,
  output logic            cpu_en_o,
  output logic            halted_o,
  output logic            bp_hit_o,
  output logic [1:0]      state_o,
  output logic [31:0]     instret_o
);

  state_t          state_q, state_d;
  logic [CNTW-1:0] remain_q, remain_d;
  logic [31:0]     instret_q, instret_d;

  logic            cpu_en;
  logic            retire_acc;
  logic            bp_match;
  logic [CNTW-1:0] load_cnt;

  // Retires only count while the core is actually enabled.
  assign cpu_en     = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign retire_acc = retire_i & cpu_en;
  assign bp_match   = bp_en_i & retire_acc & (pc_i == bp_addr_i);
  assign load_cnt   = (step_cnt_i == '0) ? CNTW'(1) : step_cnt_i;

  // Next-state, burst counter and retire counter; run toggle has top priority.
  always_comb begin
    state_d   = state_q;
    remain_d  = remain_q;
    instret_d = instret_q + 32'(retire_acc);
    case (state_q)
      ST_PAUSE, ST_BPHALT: begin
        if (run_pulse_i) begin
          state_d = ST_RUN;
        end else if (step_pulse_i) begin
          state_d  = ST_STEP;
          remain_d = load_cnt;
        end
      end
      ST_RUN: begin
        if (run_pulse_i)   state_d = ST_PAUSE;
        else if (bp_match) state_d = ST_BPHALT;
      end
      ST_STEP: begin
        if (run_pulse_i) begin
          state_d = ST_PAUSE;
        end else if (bp_match) begin
          state_d = ST_BPHALT;
        end else if (retire_acc) begin
          if (remain_q == CNTW'(1)) state_d = ST_PAUSE;
          remain_d = remain_q - CNTW'(1);
        end
      end
      default: state_d = ST_PAUSE;
    endcase
  end

  // State, burst and retire registers; reset returns to PAUSE immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_PAUSE;
      remain_q  <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      remain_q  <= remain_d;
      instret_q <= instret_d;
    end
  end

  assign cpu_en_o  = cpu_en;
  assign halted_o  = (state_q == ST_PAUSE) || (state_q == ST_BPHALT);
  assign bp_hit_o  = (state_q == ST_BPHALT);
  assign state_o   = state_q;
  assign instret_o = instret_q;

endmodule

// File: tb/tb_step_ctrl.sv
// Directed vector bench for step_ctrl.
module tb_step_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        run_pulse, step_pulse, bp_en, retire;
  logic [7:0]  step_cnt;
  logic [31:0] bp_addr, pc;
  logic        cpu_en, halted, bp_hit;
  logic [1:0]  state;
  logic [31:0] instret;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        run;
    logic        step;
    logic [7:0]  cnt;
    logic        bpe;
    logic [31:0] bpa;
    logic [31:0] pcv;
    logic        ret;
    logic [1:0]  e_st;
    logic        e_en;
    logic        e_halt;
    logic        e_hit;
    logic [31:0] e_inst;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  step_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .run_pulse_i  (run_pulse),
    .step_pulse_i (step_pulse),
    .step_cnt_i   (step_cnt),
    .bp_en_i      (bp_en),
    .bp_addr_i    (bp_addr),
    .pc_i         (pc),
    .retire_i     (retire),
    .cpu_en_o     (cpu_en),
    .halted_o     (halted),
    .bp_hit_o     (bp_hit),
    .state_o      (state),
    .instret_o    (instret)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic run, input logic step, input logic [7:0] cnt,
                              input logic bpe, input logic [31:0] pcv, input logic ret,
                              input logic [1:0] st, input logic [31:0] inst);
    vec_t v;
    v.run = run; v.step = step; v.cnt = cnt; v.bpe = bpe; v.bpa = 32'h100;
    v.pcv = pcv; v.ret = ret; v.e_st = st; v.e_inst = inst;
    v.e_en   = (st == 2'd1) || (st == 2'd2);
    v.e_halt = (st == 2'd0) || (st == 2'd3);
    v.e_hit  = (st == 2'd3);
    return v;
  endfunction

  task automatic drive(input logic run, input logic step, input logic [7:0] cnt,
                       input logic ret);
    run_pulse = run; step_pulse = step; step_cnt = cnt; retire = ret;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'd0, 1'b0);
    bp_en = 1'b0; bp_addr = 32'h100; pc = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state held through 20 idle cycles
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("idle_state", 32'(state), 32'd0);
      check("idle_cpu_en", 32'(cpu_en), 32'd0);
      check("idle_halted", 32'(halted), 32'd1);
      check("idle_bp_hit", 32'(bp_hit), 32'd0);
      check("idle_instret", instret, 32'd0);
    end

    //             run   step  cnt   bpe   pc          ret   state inst
    vecs.push_back(mk(1'b0, 1'b1, 8'd3, 1'b0, 32'h0,   1'b0, 2'd2, 32'd0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd3, 1'b0, 32'h0,   1'b1, 2'd2, 32'd1));
    vecs.push_back(mk(1'b0, 1'b0, 8'd3, 1'b0, 32'h0,   1'b1, 2'd2, 32'd2));
    vecs.push_back(mk(1'b0, 1'b0, 8'd3, 1'b0, 32'h0,   1'b1, 2'd0, 32'd3));
    vecs.push_back(mk(1'b0, 1'b0, 8'd3, 1'b0, 32'h0,   1'b1, 2'd0, 32'd3));
    // step_cnt 0 behaves as 1
    vecs.push_back(mk(1'b0, 1'b1, 8'd0, 1'b0, 32'h0,   1'b0, 2'd2, 32'd3));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 32'h0,   1'b0, 2'd2, 32'd3));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 32'h0,   1'b1, 2'd0, 32'd4));
    // step_pulse mid-burst ignored
    vecs.push_back(mk(1'b0, 1'b1, 8'd2, 1'b0, 32'h0,   1'b0, 2'd2, 32'd4));
    vecs.push_back(mk(1'b0, 1'b1, 8'd5, 1'b0, 32'h0,   1'b1, 2'd2, 32'd5));
    vecs.push_back(mk(1'b0, 1'b0, 8'd5, 1'b0, 32'h0,   1'b1, 2'd0, 32'd6));
    // free run into breakpoint at 0x100
    vecs.push_back(mk(1'b1, 1'b0, 8'd0, 1'b1, 32'hF0,  1'b0, 2'd1, 32'd6));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b1, 32'hF4,  1'b1, 2'd1, 32'd7));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b1, 32'hF8,  1'b1, 2'd1, 32'd8));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b1, 32'hFC,  1'b1, 2'd1, 32'd9));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b1, 32'h100, 1'b1, 2'd3, 32'd10));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b1, 32'h100, 1'b1, 2'd3, 32'd10));
    // resume, next retire does not re-halt
    vecs.push_back(mk(1'b1, 1'b0, 8'd0, 1'b1, 32'h100, 1'b0, 2'd1, 32'd10));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b1, 32'h104, 1'b1, 2'd1, 32'd11));
    // run_pulse beats bp_match
    vecs.push_back(mk(1'b1, 1'b0, 8'd0, 1'b1, 32'h100, 1'b1, 2'd0, 32'd12));
    // bp_match beats last-step completion
    vecs.push_back(mk(1'b0, 1'b1, 8'd1, 1'b1, 32'h0,   1'b0, 2'd2, 32'd12));
    vecs.push_back(mk(1'b0, 1'b0, 8'd1, 1'b1, 32'h100, 1'b1, 2'd3, 32'd13));
    // step out of BPHALT
    vecs.push_back(mk(1'b0, 1'b1, 8'd2, 1'b1, 32'h100, 1'b0, 2'd2, 32'd13));
    vecs.push_back(mk(1'b0, 1'b0, 8'd2, 1'b1, 32'h104, 1'b1, 2'd2, 32'd14));
    vecs.push_back(mk(1'b0, 1'b0, 8'd2, 1'b1, 32'h108, 1'b1, 2'd0, 32'd15));
    // breakpoint disabled
    vecs.push_back(mk(1'b1, 1'b0, 8'd0, 1'b0, 32'h0,   1'b0, 2'd1, 32'd15));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 32'h100, 1'b1, 2'd1, 32'd16));
    vecs.push_back(mk(1'b1, 1'b0, 8'd0, 1'b0, 32'h104, 1'b0, 2'd0, 32'd16));

    foreach (vecs[i]) begin
      drive(vecs[i].run, vecs[i].step, vecs[i].cnt, vecs[i].ret);
      bp_en = vecs[i].bpe; bp_addr = vecs[i].bpa; pc = vecs[i].pcv;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].e_st));
      check($sformatf("v%0d_cpu_en", i), 32'(cpu_en), 32'(vecs[i].e_en));
      check($sformatf("v%0d_halted", i), 32'(halted), 32'(vecs[i].e_halt));
      check($sformatf("v%0d_bp_hit", i), 32'(bp_hit), 32'(vecs[i].e_hit));
      check($sformatf("v%0d_instret", i), instret, vecs[i].e_inst);
    end

    // Asynchronous reset mid-burst with remain=2
    bp_en = 1'b0;
    drive(1'b0, 1'b1, 8'd3, 1'b0);
    @(posedge clk); @(negedge clk);
    drive(1'b0, 1'b0, 8'd3, 1'b1);
    @(posedge clk); @(negedge clk);
    check("pre_rst_state", 32'(state), 32'd2);
    check("pre_rst_instret", instret, 32'd17);
    drive(1'b0, 1'b0, 8'd3, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("async_rst_cpu_en", 32'(cpu_en), 32'd0);
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_instret", instret, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b1, 8'd1, 1'b0);
    @(posedge clk); @(negedge clk);
    check("post_rst_step_state", 32'(state), 32'd2);
    drive(1'b0, 1'b0, 8'd1, 1'b1);
    @(posedge clk); @(negedge clk);
    check("post_rst_done_state", 32'(state), 32'd0);
    check("post_rst_instret", instret, 32'd1);
    check("post_rst_cpu_en", 32'(cpu_en), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
